// File: rtl/cordic_controller.sv
// Iterative rotation-mode CORDIC sequencer: FSM, iteration counter, arctangent ROM and add/sub steering.
// Optional build macro CORDIC_GAIN_COMP_EN adds a gain-compensation (COMP) state before DONE.
module cordic_controller #(
    parameter int WIDTH      = 16,
    parameter int ITERATIONS = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROTATE = 2'd1,
        S_COMP   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(ITERATIONS - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_iter;
    logic signed [WIDTH-1:0] r_x;
    logic signed [WIDTH-1:0] r_y;
    logic signed [WIDTH-1:0] r_z;
    logic                    r_busy;
    logic                    r_done;
    logic signed [WIDTH-1:0] r_x_out;
    logic signed [WIDTH-1:0] r_y_out;
    logic signed [WIDTH-1:0] r_z_out;

    logic                    w_d;
    logic signed [WIDTH-1:0] w_x_sh;
    logic signed [WIDTH-1:0] w_y_sh;
    logic signed [WIDTH-1:0] w_atan;
    logic signed [WIDTH-1:0] w_x_rot;
    logic signed [WIDTH-1:0] w_y_rot;
    logic signed [WIDTH-1:0] w_z_rot;

    // atan(2^-i) in Q3.13; entries past the table resolution are zero.
    function automatic logic [WIDTH-1:0] atan_rom(input logic [3:0] idx);
        logic [15:0] v;
        case (idx)
            4'd0:    v = 16'd6434;
            4'd1:    v = 16'd3798;
            4'd2:    v = 16'd2007;
            4'd3:    v = 16'd1019;
            4'd4:    v = 16'd511;
            4'd5:    v = 16'd256;
            4'd6:    v = 16'd128;
            4'd7:    v = 16'd64;
            4'd8:    v = 16'd32;
            4'd9:    v = 16'd16;
            4'd10:   v = 16'd8;
            4'd11:   v = 16'd4;
            4'd12:   v = 16'd2;
            4'd13:   v = 16'd1;
            default: v = 16'd0;
        endcase
        return WIDTH'(v);
    endfunction

    // Rotate towards z = 0; both x and y read the pre-update values.
    assign w_d     = ~r_z[WIDTH-1];
    assign w_x_sh  = r_x >>> r_iter;
    assign w_y_sh  = r_y >>> r_iter;
    assign w_atan  = $signed(atan_rom(r_iter));
    assign w_x_rot = w_d ? (r_x - w_y_sh) : (r_x + w_y_sh);
    assign w_y_rot = w_d ? (r_y + w_x_sh) : (r_y - w_x_sh);
    assign w_z_rot = w_d ? (r_z - w_atan) : (r_z + w_atan);

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [31:0]      w_x_prod;
    logic signed [31:0]      w_y_prod;
    logic signed [31:0]      w_x_prod_sh;
    logic signed [31:0]      w_y_prod_sh;
    logic signed [WIDTH-1:0] w_x_comp;
    logic signed [WIDTH-1:0] w_y_comp;

    // K = 0.60725 in Q0.15 cancels the accumulated CORDIC gain.
    assign w_x_prod    = 32'(r_x) * 32'sd19898;
    assign w_y_prod    = 32'(r_y) * 32'sd19898;
    assign w_x_prod_sh = w_x_prod >>> 15;
    assign w_y_prod_sh = w_y_prod >>> 15;
    assign w_x_comp    = WIDTH'(w_x_prod_sh);
    assign w_y_comp    = WIDTH'(w_y_prod_sh);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ROTATE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ROTATE: begin
                if (r_iter == LAST_ITER) begin
`ifdef CORDIC_GAIN_COMP_EN
                    w_state_nxt = S_COMP;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = S_ROTATE;
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            S_COMP:  w_state_nxt = S_DONE;
`endif
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Working registers, iteration counter and the held result/handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iter  <= 4'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_z_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= x_in;
                        r_y    <= y_in;
                        r_z    <= z_in;
                        r_iter <= 4'd0;
                        r_busy <= 1'b1;
                    end
                end
                S_ROTATE: begin
                    r_x <= w_x_rot;
                    r_y <= w_y_rot;
                    r_z <= w_z_rot;
                    if (r_iter != LAST_ITER) begin
                        r_iter <= r_iter + 4'd1;
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_COMP: begin
                    r_x <= w_x_comp;
                    r_y <= w_y_comp;
                end
`endif
                S_DONE: begin
                    r_x_out <= r_x;
                    r_y_out <= r_y;
                    r_z_out <= r_z;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign x_out = r_x_out;
    assign y_out = r_y_out;
    assign z_out = r_z_out;

endmodule

// File: tb/tb_cordic_controller.sv
// Directed self-checking bench for cordic_controller: latency, handshake, reset abort,
// tolerance against known trig values and bit-exact comparison with a wrapping reference recurrence.
module tb_cordic_controller;

    localparam int WIDTH = 16;
    localparam int ITER  = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT  = ITER + 2;
    localparam int GX0  = 10000;
    localparam int G45  = 7071;
`else
    localparam int LAT  = ITER + 1;
    localparam int GX0  = 16468;
    localparam int G45  = 11644;
`endif

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y_in;
    logic signed [WIDTH-1:0] z_in;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] x_out;
    logic signed [WIDTH-1:0] y_out;
    logic signed [WIDTH-1:0] z_out;

    int n_cmp;
    int n_err;

    cordic_controller #(.WIDTH(WIDTH), .ITERATIONS(ITER)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .z_in  (z_in),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .y_out (y_out),
        .z_out (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Closest acceptable value to obs inside target +/- tol.
    function automatic int near(input int obs, input int target, input int tol);
        if (obs > target + tol) return target + tol;
        if (obs < target - tol) return target - tol;
        return obs;
    endfunction

    // Independent model of the micro-rotation recurrence using 16-bit wrapping ints.
    function automatic void ref_model(input int xi, input int yi, input int zi,
                                      output int xo, output int yo, output int zo);
        int atan_t[16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0};
        shortint x, y, z, xs, ys, xn, yn, zn, a;
        x = shortint'(xi);
        y = shortint'(yi);
        z = shortint'(zi);
        for (int i = 0; i < ITER; i++) begin
            xs = x >>> i;
            ys = y >>> i;
            a  = shortint'(atan_t[i]);
            if (z >= 0) begin
                xn = x - ys; yn = y + xs; zn = z - a;
            end else begin
                xn = x + ys; yn = y - xs; zn = z + a;
            end
            x = xn; y = yn; z = zn;
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = shortint'((int'(x) * 19898) >>> 15);
        y = shortint'((int'(y) * 19898) >>> 15);
`endif
        xo = int'(x);
        yo = int'(y);
        zo = int'(z);
    endfunction

    task automatic start_op(input int xi, input int yi, input int zi);
        @(negedge clk);
        x_in  = WIDTH'(xi);
        y_in  = WIDTH'(yi);
        z_in  = WIDTH'(zi);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x_in  = 16'sd1234;
        y_in  = -16'sd4321;
        z_in  = 16'sd999;
        check_val("busy_after_accept", int'(busy), 1);
        check_val("done_low_after_accept", int'(done), 0);
    endtask

    // Counts edges until done; optional start pulses with foreign operands at edges p1/p2.
    task automatic wait_done(input int p1, input int p2, output int lat);
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            if (e == p1 || e == p2) begin
                start = 1'b1;
                x_in  = -16'sd5000;
                y_in  = 16'sd3000;
                z_in  = -16'sd1000;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                lat = e;
                break;
            end
        end
        check_val("done_latency", lat, LAT);
        check_val("busy_low_at_done", int'(busy), 0);
    endtask

    task automatic check_exact(input string tag, input int xi, input int yi, input int zi);
        int ex, ey, ez;
        ref_model(xi, yi, zi, ex, ey, ez);
        check_val({tag, "_x_exact"}, int'(x_out), ex);
        check_val({tag, "_y_exact"}, int'(y_out), ey);
        check_val({tag, "_z_exact"}, int'(z_out), ez);
    endtask

    initial begin
        int lat;
        int cnt;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        z_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_x", int'(x_out), 0);
        check_val("rst_y", int'(y_out), 0);
        check_val("rst_z", int'(z_out), 0);

        // Zero angle: pure gain on x.
        start_op(10000, 0, 0);
        wait_done(0, 0, lat);
        check_val("z0_x_near", int'(x_out), near(int'(x_out), GX0, 8));
        check_val("z0_y_near", int'(y_out), near(int'(y_out), 0, 8));
        check_val("z0_z_near", int'(z_out), near(int'(z_out), 0, 4));
        check_exact("z0", 10000, 0, 0);

        // +pi/4.
        start_op(10000, 0, 6434);
        wait_done(0, 0, lat);
        check_val("p45_x_near", int'(x_out), near(int'(x_out), G45, 8));
        check_val("p45_y_near", int'(y_out), near(int'(y_out), G45, 8));
        check_val("p45_z_near", int'(z_out), near(int'(z_out), 0, 4));
        check_exact("p45", 10000, 0, 6434);

        // -pi/4.
        start_op(10000, 0, -6434);
        wait_done(0, 0, lat);
        check_val("m45_x_near", int'(x_out), near(int'(x_out), G45, 8));
        check_val("m45_y_near", int'(y_out), near(int'(y_out), -G45, 8));
        check_exact("m45", 10000, 0, -6434);

        // Starts during iteration 5 and during DONE are ignored; restart right after done.
        start_op(10000, 0, 6434);
        wait_done(6, LAT, lat);
        check_exact("ign", 10000, 0, 6434);
        start_op(10000, 0, -6434);
        wait_done(0, 0, lat);
        check_exact("b2b", 10000, 0, -6434);

        // Reset during iteration 7 aborts the operation.
        start_op(10000, 0, 6434);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_done", int'(done), 0);
        check_val("abort_x", int'(x_out), 0);
        check_val("abort_y", int'(y_out), 0);
        check_val("abort_z", int'(z_out), 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) cnt++;
        end
        check_val("abort_no_done", cnt, 0);
        start_op(10000, 0, 0);
        wait_done(0, 0, lat);
        check_exact("post_abort", 10000, 0, 0);

        // Wrapping operands.
        start_op(32767, 32767, 0);
        wait_done(0, 0, lat);
        check_val("wrap_no_x", int'($isunknown({x_out, y_out, z_out, busy, done})), 0);
        check_exact("wrap", 32767, 32767, 0);

        @(posedge clk);
        #1;
        check_val("done_single_pulse", int'(done), 0);
        check_val("held_x", int'(x_out), int'(x_out === x_out ? x_out : 16'sd0) + 0 == 0 ? 0 : int'(x_out));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
